// File: rtl/draw_sequencer_pkg.sv
// Shared types and widths for the draw sequencer and its VGA port mux.
package draw_sequencer_pkg;
  localparam int VGA_X_W = 8;
  localparam int VGA_Y_W = 7;
  localparam int COLOR_W = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ERASE  = 2'd1,
    S_UPDATE = 2'd2,
    S_DRAW   = 2'd3
  } state_t;

  typedef struct packed {
    logic               plot;
    logic [VGA_X_W-1:0] x;
    logic [VGA_Y_W-1:0] y;
    logic [COLOR_W-1:0] color;
  } pix_t;
endpackage

// File: rtl/draw_sequencer_if.sv
// Drawer bank + VGA plot port bundle. master = sequencer, slave = drawers/adapter.
interface draw_sequencer_if #(parameter int NUM_OBJ = 2);
  import draw_sequencer_pkg::*;

  logic [NUM_OBJ-1:0]              drw_done;
  logic [NUM_OBJ-1:0]              drw_plot;
  logic [NUM_OBJ-1:0][VGA_X_W-1:0] drw_x;
  logic [NUM_OBJ-1:0][VGA_Y_W-1:0] drw_y;
  logic [NUM_OBJ-1:0][COLOR_W-1:0] drw_color;
  logic [NUM_OBJ-1:0]              drw_en;
  logic                            drw_erase;
  logic                            pos_update;
  logic [VGA_X_W-1:0]              vga_x;
  logic [VGA_Y_W-1:0]              vga_y;
  logic [COLOR_W-1:0]              vga_color;
  logic                            vga_plot;

  modport master (
    input  drw_done, drw_plot, drw_x, drw_y, drw_color,
    output drw_en, drw_erase, pos_update, vga_x, vga_y, vga_color, vga_plot
  );
  modport slave (
    output drw_done, drw_plot, drw_x, drw_y, drw_color,
    input  drw_en, drw_erase, pos_update, vga_x, vga_y, vga_color, vga_plot
  );
endinterface

// File: rtl/draw_sequencer_port_mux.sv
// Registered NUM_OBJ:1 pixel mux; plot is gated off when no drawer is active.
module draw_sequencer_port_mux
  import draw_sequencer_pkg::*;
#(
  parameter int NUM_OBJ = 2,
  parameter int IDX_W   = 1
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [IDX_W-1:0]                i_sel,
  input  logic                            i_gate,
  input  logic [NUM_OBJ-1:0]              i_plot,
  input  logic [NUM_OBJ-1:0][VGA_X_W-1:0] i_x,
  input  logic [NUM_OBJ-1:0][VGA_Y_W-1:0] i_y,
  input  logic [NUM_OBJ-1:0][COLOR_W-1:0] i_color,
  output pix_t                            o_pix
);
  pix_t r_pix;

  // One-cycle pipeline stage from the selected drawer to the VGA port
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pix <= '0;
    end else begin
      r_pix.plot  <= i_gate & i_plot[i_sel];
      r_pix.x     <= i_x[i_sel];
      r_pix.y     <= i_y[i_sel];
      r_pix.color <= i_color[i_sel];
    end
  end

  assign o_pix = r_pix;
endmodule

// File: rtl/draw_sequencer.sv
// Frame scheduler: erase all objects, strobe position update, redraw all objects.
// Erasing everything before drawing anything keeps overlapping objects intact.
module draw_sequencer
  import draw_sequencer_pkg::*;
#(
  parameter int NUM_OBJ = 2,
  parameter int IDX_W   = 1,
  parameter int TIMEOUT = 4095,
  parameter int TO_W    = 12
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             frame_tick,
  input  logic             run,
  draw_sequencer_if.master bus,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
);
  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [TO_W-1:0]    r_wd, w_wd_nxt;
  logic               r_pending, w_pending_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_overrun, w_overrun_nxt;
  logic               r_toerr, w_toerr_nxt;
  logic [NUM_OBJ-1:0] w_en;
  logic               w_erase, w_pos_upd, w_active, w_done, w_to, w_last;
  pix_t               w_pix;

  assign w_active = (r_state == S_ERASE) || (r_state == S_DRAW);
  assign w_done   = bus.drw_done[r_idx];
  // Watchdog hits its limit on the TIMEOUT-th cycle of a pass
  assign w_to     = (r_wd == TO_W'(TIMEOUT - 1));
  assign w_last   = (r_idx == IDX_W'(NUM_OBJ - 1));

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_wd      <= '0;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_toerr   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_wd      <= w_wd_nxt;
      r_pending <= w_pending_nxt;
      r_busy    <= w_busy_nxt;
      r_overrun <= w_overrun_nxt;
      r_toerr   <= w_toerr_nxt;
    end
  end

  // Next-state, pass sequencing and drawer enables
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_wd_nxt      = r_wd;
    w_pending_nxt = r_pending;
    w_busy_nxt    = r_busy;
    w_overrun_nxt = r_overrun;
    w_toerr_nxt   = r_toerr;
    w_en          = '0;
    w_erase       = 1'b0;
    w_pos_upd     = 1'b0;

    // A tick during a frame is remembered once; more ticks collapse into it
    if (frame_tick && r_busy) begin
      w_pending_nxt = 1'b1;
      w_overrun_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if ((frame_tick || r_pending) && run) begin
          w_state_nxt   = S_ERASE;
          w_idx_nxt     = '0;
          w_wd_nxt      = '0;
          w_pending_nxt = 1'b0;
          w_busy_nxt    = 1'b1;
        end
      end
      S_ERASE, S_DRAW: begin
        // Enable drops the same cycle done rises so the drawer parks cleanly
        w_en[r_idx] = ~w_done;
        w_erase     = (r_state == S_ERASE);
        w_wd_nxt    = r_wd + TO_W'(1);
        if (w_to && !w_done) w_toerr_nxt = 1'b1;
        if (w_done || w_to) begin
          w_wd_nxt = '0;
          if (w_last) begin
            w_idx_nxt = '0;
            if (r_state == S_ERASE) begin
              w_state_nxt = S_UPDATE;
            end else begin
              w_state_nxt = S_IDLE;
              w_busy_nxt  = 1'b0;
            end
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      S_UPDATE: begin
        w_pos_upd   = 1'b1;
        w_state_nxt = S_DRAW;
        w_wd_nxt    = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  draw_sequencer_port_mux #(.NUM_OBJ(NUM_OBJ), .IDX_W(IDX_W)) u_mux (
    .clk     (clk),
    .resetn  (resetn),
    .i_sel   (r_idx),
    .i_gate  (w_active),
    .i_plot  (bus.drw_plot),
    .i_x     (bus.drw_x),
    .i_y     (bus.drw_y),
    .i_color (bus.drw_color),
    .o_pix   (w_pix)
  );

  assign bus.drw_en     = w_en;
  assign bus.drw_erase  = w_erase;
  assign bus.pos_update = w_pos_upd;
  assign bus.vga_plot   = w_pix.plot;
  assign bus.vga_x      = w_pix.x;
  assign bus.vga_y      = w_pix.y;
  assign bus.vga_color  = w_pix.color;
  assign busy           = r_busy;
  assign overrun        = r_overrun;
  assign timeout_err    = r_toerr;
endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: behavioural rectangle drawers, pixel-list reference model.
module tb_draw_sequencer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic tick0 = 1'b0, run0 = 1'b0, tick1 = 1'b0, run1 = 1'b0;
  logic busy0, ovr0, toe0, busy1, ovr1, toe1;

  always #5 clk = ~clk;

  draw_sequencer_if #(.NUM_OBJ(2)) b0();
  draw_sequencer_if #(.NUM_OBJ(2)) b1();

  draw_sequencer dut (
    .clk(clk), .resetn(resetn), .frame_tick(tick0), .run(run0), .bus(b0),
    .busy(busy0), .overrun(ovr0), .timeout_err(toe0)
  );
  draw_sequencer #(.TIMEOUT(64), .TO_W(7)) dut_to (
    .clk(clk), .resetn(resetn), .frame_tick(tick1), .run(run1), .bus(b1),
    .busy(busy1), .overrun(ovr1), .timeout_err(toe1)
  );

  // Drawers 0,1 feed dut; 2,3 feed dut_to (drawer 3 never finishes)
  localparam int X0   [4] = '{60, 100, 60, 100};
  localparam int Y0   [4] = '{50, 20, 50, 20};
  localparam int WM   [4] = '{10, 4, 3, 4};
  localparam int HM   [4] = '{10, 4, 3, 4};
  localparam int HANG [4] = '{0, 0, 0, 1};

  int cx [4];
  int cy [4];
  logic [3:0] dn;
  wire  [3:0] den = {b1.drw_en, b0.drw_en};

  // Behavioural drawer: raster-scan (W+1)x(H+1) while enabled, park at origin when not
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin cx[i] <= 0; cy[i] <= 0; end
      dn <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!den[i]) begin
          cx[i] <= 0; cy[i] <= 0; dn[i] <= 1'b0;
        end else if (cx[i] == WM[i] && cy[i] == HM[i]) begin
          cx[i] <= 0; cy[i] <= 0;
          if (HANG[i] == 0) dn[i] <= 1'b1;
        end else if (cx[i] == WM[i]) begin
          cx[i] <= 0; cy[i] <= cy[i] + 1;
        end else begin
          cx[i] <= cx[i] + 1;
        end
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_drv
    assign b0.drw_done[g]  = dn[g];
    assign b0.drw_plot[g]  = den[g] & ~dn[g];
    assign b0.drw_x[g]     = 8'(X0[g] + cx[g]);
    assign b0.drw_y[g]     = 7'(Y0[g] + cy[g]);
    assign b0.drw_color[g] = b0.drw_erase ? 3'b000 : 3'b001;
    assign b1.drw_done[g]  = dn[g+2];
    assign b1.drw_plot[g]  = den[g+2] & ~dn[g+2];
    assign b1.drw_x[g]     = 8'(X0[g+2] + cx[g+2]);
    assign b1.drw_y[g]     = 7'(Y0[g+2] + cy[g+2]);
    assign b1.drw_color[g] = b1.drw_erase ? 3'b000 : 3'b001;
  end

  // Monitor: collect VGA pixels and strobes, flag handshake violations
  logic [17:0] got [$];
  int pu_at [$];
  int viol = 0, en1_cnt = 0, pu1_cnt = 0;
  always @(negedge clk) begin
    if (b0.vga_plot) got.push_back({b0.vga_x, b0.vga_y, b0.vga_color});
    if (b0.pos_update) pu_at.push_back(got.size());
    viol    <= viol + (((dn & den) != 4'b0) ? 1 : 0)
                    + (($countones(b0.drw_en) > 1 || $countones(b1.drw_en) > 1) ? 1 : 0);
    en1_cnt <= en1_cnt + (b1.drw_en[1] ? 1 : 0);
    pu1_cnt <= pu1_cnt + (b1.pos_update ? 1 : 0);
  end

  int n_assert = 0, n_fail = 0;
  logic [17:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Reference frame: erase obj0, obj1 (color 0), then draw obj0, obj1 (color 1), raster order
  task automatic add_frame();
    for (int ph = 0; ph < 2; ph++)
      for (int o = 0; o < 2; o++)
        for (int y = 0; y <= HM[o]; y++)
          for (int x = 0; x <= WM[o]; x++)
            exp_q.push_back({8'(X0[o] + x), 7'(Y0[o] + y), (ph == 1) ? 3'b001 : 3'b000});
  endtask

  task automatic cmp_pix(input string tag);
    int bad, first;
    bad = 0; first = -1;
    chk({tag, " pixel count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    if (bad != 0) $display("first pixel difference at index %0d: got %h want %h",
                           first, got[first], exp_q[first]);
    chk({tag, " pixel mismatches"}, 64'(bad), 64'd0);
  endtask

  task automatic clear_logs();
    got.delete(); pu_at.delete(); exp_q.delete();
  endtask

  task automatic wait_idle(input string tag, input int which, input int budget);
    int k;
    k = 0;
    while (((which == 0) ? busy0 : busy1) && k < budget) begin cyc(); k++; end
    chk({tag, " reached idle"}, (which == 0) ? busy0 : busy1, 1'b0);
  endtask

  task automatic wait_pu(input string tag);
    int k;
    k = 0;
    while (pu_at.size() == 0 && k < 400) begin cyc(); k++; end
    chk({tag, " pos_update seen"}, 64'(pu_at.size()), 64'd1);
  endtask

  task automatic pulse0();
    tick0 = 1'b1; cyc(); tick0 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    resetn = 1'b0; cyc(3);
    chk("rst drw_en", b0.drw_en, 0);
    chk("rst drw_erase", b0.drw_erase, 0);
    chk("rst pos_update", b0.pos_update, 0);
    chk("rst vga", {b0.vga_plot, b0.vga_x, b0.vga_y, b0.vga_color}, 0);
    chk("rst flags", {busy0, ovr0, toe0, busy1, ovr1, toe1}, 0);
    resetn = 1'b1; cyc($urandom_range(1, 5));

    // Single frame: erase0, erase1, pos_update, draw0, draw1
    run0 = 1'b1; pulse0();
    chk("start busy", busy0, 1);
    chk("start en", b0.drw_en, 2'b01);
    chk("start erase", b0.drw_erase, 1);
    add_frame();
    wait_idle("frame1", 0, 2000);
    cmp_pix("frame1");
    chk("frame1 pos_update count", 64'(pu_at.size()), 64'd1);
    chk("frame1 plots before pos_update", (pu_at.size() > 0) ? 64'(pu_at[0]) : 64'hFFFF, 64'd146);
    chk("frame1 no overrun", ovr0, 0);

    // Overrun: tick mid-DRAW plus a third tick -> exactly one extra frame
    clear_logs();
    pulse0();
    wait_pu("ovr");
    cyc($urandom_range(5, 120));
    pulse0();
    cyc($urandom_range(1, 10));
    pulse0();
    chk("overrun flag", ovr0, 1);
    wait_idle("ovr frame A", 0, 2000);
    cyc();
    chk("pending frame restarts one cycle after idle", busy0, 1);
    wait_idle("ovr frame B", 0, 2000);
    cyc(30);
    chk("no third frame", busy0, 0);
    add_frame(); add_frame();
    cmp_pix("ovr frames");
    chk("ovr pos_update count", 64'(pu_at.size()), 64'd2);

    // Reset during DRAW: outputs clear asynchronously, then wait for a tick
    clear_logs();
    pulse0();
    wait_pu("rst mid-draw");
    cyc($urandom_range(3, 100));
    chk("pre-reset drawer active", (b0.drw_en != 2'b00), 1);
    #1 resetn = 1'b0;
    #1;
    chk("async rst drw_en", b0.drw_en, 0);
    chk("async rst vga", {b0.vga_plot, b0.vga_x, b0.vga_y, b0.vga_color}, 0);
    chk("async rst flags", {busy0, ovr0, toe0, b0.drw_erase, b0.pos_update}, 0);
    cyc(2); resetn = 1'b1;
    cyc(20);
    chk("idle after reset", busy0, 0);

    // run dropped mid-ERASE: frame completes, later tick ignored
    clear_logs();
    pulse0();
    cyc($urandom_range(5, 60));
    chk("mid-erase", b0.drw_erase, 1);
    run0 = 1'b0;
    add_frame();
    wait_idle("run0 frame", 0, 2000);
    cmp_pix("run0 frame");
    pulse0();
    cyc(10);
    chk("tick with run=0 ignored", busy0, 0);
    chk("tick with run=0 no overrun", ovr0, 0);
    chk("no pixels after ignored tick", 64'(got.size()), 64'd292);

    // Watchdog: drawer 1 of dut_to never finishes, TIMEOUT=64
    run1 = 1'b1; tick1 = 1'b1; cyc(); tick1 = 1'b0;
    wait_idle("timeout frame", 1, 1000);
    chk("timeout_err set", toe1, 1);
    chk("aborted passes each 64 cycles", 64'(en1_cnt), 64'd128);
    chk("timeout frame pos_update", 64'(pu1_cnt), 64'd1);
    chk("main dut no timeout", toe0, 0);
    chk("no done/enable overlap", 64'(viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
